// File: rtl/lane_tick_scheduler.sv
// Shared prescaler plus per-lane period counters issuing 1-clk lane_tick pulses, with run/pause/stop sequencing and difficulty level.
// lane_tick is registered, one cycle after the expiring base tick; there is no backpressure because pulses are fire-and-forget enables.
module lane_tick_scheduler #(
   parameter int NUM_LANES   = 4,
   parameter int PRESCALE    = 4,
   parameter int BASE_PERIOD = 4,
   parameter int LANE_STEP   = 2,
   parameter int MIN_PERIOD  = 1,
   parameter int MAX_LEVEL   = 7,
   parameter int LEVEL_W     = 3,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pause_toggle,
   input  logic                 stop,
   input  logic                 level_up,
   output logic [NUM_LANES-1:0] lane_tick,
   output logic [LEVEL_W-1:0]   level,
   output logic                 running,
   output logic                 paused
);

   localparam int PW = $clog2(PRESCALE);
   localparam int RW = ((CNT_W > LEVEL_W) ? CNT_W : LEVEL_W) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PW-1:0]        r_presc;
   logic [CNT_W-1:0]     r_cnt [NUM_LANES];
   logic [CNT_W-1:0]     w_reload [NUM_LANES];
   logic [NUM_LANES-1:0] r_lane_tick;
   logic [LEVEL_W-1:0]   r_level;
   logic                 r_running;
   logic                 r_paused;
   logic                 w_base_tick;

   assign lane_tick = r_lane_tick;
   assign level     = r_level;
   assign running   = r_running;
   assign paused    = r_paused;

   assign w_base_tick = (r_state == ST_RUN) && (r_presc == PW'(PRESCALE - 1));

   // Compare before subtracting so a high level can never wrap the period.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (RW'(BASE_PERIOD + i * LANE_STEP) <= RW'(r_level) + RW'(MIN_PERIOD)) begin
            w_reload[i] = CNT_W'(MIN_PERIOD);
         end else begin
            w_reload[i] = CNT_W'(RW'(BASE_PERIOD + i * LANE_STEP) - RW'(r_level));
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (!stop && start) w_state_nxt = ST_RUN;
         ST_RUN:    if (stop) w_state_nxt = ST_IDLE;
                    else if (pause_toggle) w_state_nxt = ST_PAUSED;
         ST_PAUSED: if (stop) w_state_nxt = ST_IDLE;
                    else if (pause_toggle) w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_presc     <= '0;
         r_lane_tick <= '0;
         r_level     <= '0;
         r_running   <= 1'b0;
         r_paused    <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_running   <= (w_state_nxt == ST_RUN);
         r_paused    <= (w_state_nxt == ST_PAUSED);
         r_lane_tick <= '0;
         if (stop) begin
            // Stop kills any pulse that would have expired on this edge.
            r_presc <= '0;
            r_level <= '0;
            for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_presc <= '0;
                     for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= w_reload[i];
                  end
               end
               ST_RUN: begin
                  if (w_base_tick) r_presc <= '0;
                  else             r_presc <= r_presc + 1'b1;
                  if (w_base_tick) begin
                     for (int i = 0; i < NUM_LANES; i++) begin
                        if (r_cnt[i] == CNT_W'(1)) begin
                           r_cnt[i]       <= w_reload[i];
                           r_lane_tick[i] <= 1'b1;
                        end else begin
                           r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                     end
                  end
                  if (level_up && (r_level != LEVEL_W'(MAX_LEVEL))) r_level <= r_level + 1'b1;
               end
               ST_PAUSED: begin
                  if (level_up && (r_level != LEVEL_W'(MAX_LEVEL))) r_level <= r_level + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Scoreboard bench for lane_tick_scheduler: expected pulse cycles are queued per lane when stimulus is
// applied and popped as pulses are observed on the falling edge.
module tb_lane_tick_scheduler;
   localparam int NL       = 4;
   localparam int PRE      = 4;
   localparam int BASE     = 4;
   localparam int STEP     = 2;
   localparam int MINP     = 1;
   localparam int MAXL     = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          pause_toggle = 1'b0;
   logic          stop = 1'b0;
   logic          level_up = 1'b0;
   logic [NL-1:0] lane_tick;
   logic [2:0]    level;
   logic          running;
   logic          paused;

   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            expq [NL][$];
   int            lu [$];
   logic [NL-1:0] prev_tick = '0;

   lane_tick_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
      .stop(stop), .level_up(level_up), .lane_tick(lane_tick), .level(level),
      .running(running), .paused(paused)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: cycle %0d expected completion before time limit", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (lane_tick[l]) begin
            if (expq[l].size() > 0)
               check($sformatf("tick_time_l%0d", l), cyc, expq[l].pop_front());
            else
               check($sformatf("spurious_tick_l%0d", l), int'(lane_tick[l]), 0);
            if (prev_tick[l])
               check($sformatf("pulse_width_l%0d", l), int'(prev_tick[l] & lane_tick[l]), 0);
         end else if (expq[l].size() > 0 && expq[l][0] <= cyc) begin
            check($sformatf("missed_tick_l%0d@%0d", l, expq[l].pop_front()), int'(lane_tick[l]), 1);
         end
      end
      prev_tick = lane_tick;
   end

   // Level in force just before edge e, from the scheduled level_up edges.
   function automatic int level_at(input int e);
      int n = 0;
      foreach (lu[k]) if (lu[k] < e) n++;
      return (n > MAXL) ? MAXL : n;
   endfunction

   function automatic int period(input int lane, input int lvl);
      int b = BASE + lane * STEP;
      return (b - lvl < MINP) ? MINP : b - lvl;
   endfunction

   // Pulse cycles for a run started at edge s; base ticks after pause edge pe slip by sh cycles.
   function automatic void gen(input int s, input int tend, input int pe, input int sh);
      for (int l = 0; l < NL; l++) begin
         int t = s + PRE * period(l, level_at(s));
         while (1) begin
            int m = (pe > 0 && t > pe) ? t + sh : t;
            if (m > tend) break;
            expq[l].push_back(m);
            t += PRE * period(l, level_at(t));
         end
      end
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Return at the falling edge just before posedge number e.
   task automatic at_edge(input int e);
      while (cyc < e - 1) @(negedge clk);
   endtask

   task automatic do_start(output int s);
      s = cyc + 1;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic end_window(input int e);
      at_edge(e);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_lane_tick", int'(lane_tick), 0);
      check("stop_running", int'(running), 0);
      check("stop_level", int'(level), 0);
      for (int l = 0; l < NL; l++) begin
         check($sformatf("pending_l%0d", l), expq[l].size(), 0);
         expq[l].delete();
      end
      step();
   endtask

   int s;

   initial begin
      repeat (2) step();
      check("rst_lane_tick", int'(lane_tick), 0);
      check("rst_level", int'(level), 0);
      check("rst_running", int'(running), 0);
      check("rst_paused", int'(paused), 0);
      reset = 1'b0;
      step();

      // Plain run at level 0.
      do_start(s);
      check("run_running", int'(running), 1);
      check("run_paused", int'(paused), 0);
      lu.delete();
      gen(s, s + 200, 0, 0);
      end_window(s + 201);

      // Difficulty ramp: 5 level_ups, then 9 more to saturate.
      do_start(s);
      lu.delete();
      for (int k = 1; k <= 5; k++) lu.push_back(s + k);
      for (int k = 101; k <= 109; k++) lu.push_back(s + k);
      gen(s, s + 160, 0, 0);
      level_up = 1'b1;
      repeat (5) step();
      level_up = 1'b0;
      check("level_5", int'(level), 5);
      at_edge(s + 101);
      level_up = 1'b1;
      repeat (9) step();
      level_up = 1'b0;
      check("level_sat", int'(level), MAXL);
      end_window(s + 161);

      // Pause for 30 cycles; remaining count is preserved across the pause.
      do_start(s);
      lu.delete();
      gen(s, s + 200, s + 5, 30);
      at_edge(s + 5);
      pause_toggle = 1'b1;
      step();
      pause_toggle = 1'b0;
      check("pause_paused", int'(paused), 1);
      check("pause_running", int'(running), 0);
      repeat (15) step();
      check("pause_hold", int'(paused), 1);
      at_edge(s + 35);
      pause_toggle = 1'b1;
      step();
      pause_toggle = 1'b0;
      check("resume_running", int'(running), 1);
      check("resume_paused", int'(paused), 0);
      end_window(s + 201);

      // Pause coinciding with the base tick that expires lane 0.
      do_start(s);
      expq[0].push_back(s + 16);
      at_edge(s + 16);
      pause_toggle = 1'b1;
      step();
      pause_toggle = 1'b0;
      check("coinc_tick0", int'(lane_tick[0]), 1);
      check("coinc_paused", int'(paused), 1);
      end_window(s + 20);

      // Stop with level_up on an expiring edge, then restart matches a fresh run.
      do_start(s);
      level_up = 1'b1;
      repeat (3) step();
      level_up = 1'b0;
      at_edge(s + 16);
      check("pre_stop_level", int'(level), 3);
      stop = 1'b1;
      level_up = 1'b1;
      step();
      stop = 1'b0;
      level_up = 1'b0;
      check("stoplu_lane_tick", int'(lane_tick), 0);
      check("stoplu_level", int'(level), 0);
      check("stoplu_running", int'(running), 0);
      step();
      do_start(s);
      lu.delete();
      gen(s, s + 200, 0, 0);
      end_window(s + 201);

      // Reset mid-run together with start.
      do_start(s);
      gen(s, s + 20, 0, 0);
      at_edge(s + 21);
      reset = 1'b1;
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rst2_lane_tick", int'(lane_tick), 0);
      check("rst2_level", int'(level), 0);
      check("rst2_running", int'(running), 0);
      check("rst2_paused", int'(paused), 0);
      repeat (40) step();
      check("rst2_idle", int'(running), 0);
      for (int l = 0; l < NL; l++) check($sformatf("rst2_pending_l%0d", l), expq[l].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
